// File: rtl/uart_pkg.sv
// Shared types for the UART receiver: FSM state encoding and parity mode codes.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;
endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, oversampling tick counter and 3-sample majority vote.
// Strobes are combinational and valid only on baud_tick cycles.
module uart_rx_sampler #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic baud_tick,
  input  logic rx,
  input  logic idle,
  output logic rx_s,
  output logic vote_vld,
  output logic wrap,
  output logic vote
);
  localparam int H  = OVERSAMPLE / 2;
  localparam int CW = $clog2(OVERSAMPLE);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   s_a, s_b;
  logic                   on_tick;

  assign rx_s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '1;
      cnt  <= '0;
      s_a  <= 1'b1;
      s_b  <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
      if (baud_tick) begin
        // While idle the falling-edge tick itself counts as sample 0 of the start bit
        if (idle)
          cnt <= rx_s ? '0 : CW'(1);
        else if (cnt == CW'(OVERSAMPLE - 1))
          cnt <= '0;
        else
          cnt <= cnt + CW'(1);
        if (cnt == CW'(H - 1)) s_a <= rx_s;
        if (cnt == CW'(H))     s_b <= rx_s;
      end
    end
  end

  assign on_tick  = baud_tick & ~idle;
  assign vote_vld = on_tick & (cnt == CW'(H + 1));
  assign wrap     = on_tick & (cnt == CW'(OVERSAMPLE - 1));
  assign vote     = (s_a & s_b) | (s_a & rx_s) | (s_b & rx_s);
endmodule

// File: rtl/uart_rx_ext.sv
// UART receiver with runtime frame format, parity/framing/break detection
// and a single-entry valid/ready holding register that flags overrun.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int MAX_BITS    = 9,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        baud_tick,
  input  logic                        rx,
  input  logic [$clog2(MAX_BITS+1)-1:0] cfg_bits,
  input  logic [1:0]                  cfg_parity,
  input  logic                        cfg_stop2,
  output logic [MAX_BITS-1:0]         m_data,
  output logic                        m_err_frame,
  output logic                        m_err_parity,
  output logic                        m_break,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        err_overrun
);
  localparam int BW = $clog2(MAX_BITS + 1);

  state_t              state, state_n;
  logic [BW-1:0]       idx, idx_n, bits_q, bits_n;
  logic [1:0]          par_q, par_n;
  logic                stop2_q, stop2_n, stop_sec, stop_sec_n;
  logic [MAX_BITS-1:0] data, data_n;
  logic                perr, perr_n, ferr, ferr_n, zero, zero_n;
  logic                done, brk, par_en, exp_par;
  logic                rx_s, vote_vld, wrap, vote;

  uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE), .SYNC_STAGES(SYNC_STAGES)) u_samp (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx), .idle(state == IDLE),
    .rx_s(rx_s), .vote_vld(vote_vld), .wrap(wrap), .vote(vote)
  );

  assign par_en  = (par_q == PAR_ODD) || (par_q == PAR_EVEN);
  assign exp_par = (par_q == PAR_EVEN) ? ^data : ~^data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      bits_q   <= '0;
      par_q    <= PAR_NONE;
      stop2_q  <= 1'b0;
      stop_sec <= 1'b0;
      data     <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      zero     <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      bits_q   <= bits_n;
      par_q    <= par_n;
      stop2_q  <= stop2_n;
      stop_sec <= stop_sec_n;
      data     <= data_n;
      perr     <= perr_n;
      ferr     <= ferr_n;
      zero     <= zero_n;
    end
  end

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    bits_n     = bits_q;
    par_n      = par_q;
    stop2_n    = stop2_q;
    stop_sec_n = stop_sec;
    data_n     = data;
    perr_n     = perr;
    ferr_n     = ferr;
    zero_n     = zero;
    done       = 1'b0;
    brk        = 1'b0;
    case (state)
      IDLE: if (baud_tick && !rx_s) begin
        state_n    = START;
        bits_n     = cfg_bits;
        par_n      = cfg_parity;
        stop2_n    = cfg_stop2;
        idx_n      = '0;
        stop_sec_n = 1'b0;
        data_n     = '0;
        perr_n     = 1'b0;
        ferr_n     = 1'b0;
        zero_n     = 1'b1;
      end
      START: begin
        if (vote_vld && vote) state_n = IDLE;
        else if (wrap)        state_n = DATA;
      end
      DATA: begin
        if (vote_vld) begin
          data_n[idx] = vote;
          if (vote) zero_n = 1'b0;
        end
        if (wrap) begin
          if (idx == bits_q - BW'(1)) state_n = par_en ? PARITY : STOP;
          else                        idx_n   = idx + BW'(1);
        end
      end
      PARITY: begin
        if (vote_vld) begin
          if (vote)            zero_n = 1'b0;
          if (vote != exp_par) perr_n = 1'b1;
        end
        if (wrap) state_n = STOP;
      end
      STOP: begin
        if (vote_vld) begin
          if (!vote) ferr_n = 1'b1;
          // Break is judged on the first stop bit only; completion of the last stop bit is mid-bit for resync margin
          if (!stop_sec && !vote && zero) begin
            done    = 1'b1;
            brk     = 1'b1;
            state_n = BREAK_WAIT;
          end else if (!stop2_q || stop_sec) begin
            done    = 1'b1;
            state_n = IDLE;
          end
        end else if (wrap) begin
          stop_sec_n = 1'b1;
        end
      end
      BREAK_WAIT: if (baud_tick && rx_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_data       <= '0;
      m_err_frame  <= 1'b0;
      m_err_parity <= 1'b0;
      m_break      <= 1'b0;
      m_valid      <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      err_overrun <= 1'b0;
      if (done) begin
        if (!m_valid || m_ready) begin
          m_data       <= brk ? '0 : data_n;
          m_err_frame  <= ferr_n;
          m_err_parity <= brk ? 1'b0 : perr_n;
          m_break      <= brk;
          m_valid      <= 1'b1;
        end else begin
          err_overrun <= 1'b1;
        end
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/uart_rx_ext.md
Name: uart_rx_ext

Overview:
Parametrised next-generation UART receiver.
- Runs from an external oversampling tick, so one baud generator serves many channels.
- Frame format is runtime-configurable (5..MAX_BITS data bits, none/odd/even parity, 1 or 2 stop bits).
- Each bit is decided by a 3-sample majority vote.
- Delivers each frame with error status over a valid/ready stream, with overrun and break detection.
- Sits between the pin synchroniser domain and the command/FIFO logic.

Parameters:
MAX_BITS, 9, maximum data bits per frame; width of m_data.
OVERSAMPLE, 16, baud_tick pulses per bit; even, >= 8.
SYNC_STAGES, 2, rx synchroniser flops; >= 2.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
baud_tick  in  1  one-cycle enable at OVERSAMPLE x baud rate
rx  in  1  asynchronous serial line; idle high
cfg_bits  in  $clog2(MAX_BITS+1)  data bits per frame, 5..MAX_BITS
cfg_parity  in  2  0 none, 1 odd, 2 even, 3 treated as none
cfg_stop2  in  1  0 = one stop bit, 1 = two stop bits
m_data  out  MAX_BITS  received data, LSB-first on the line, right-aligned, unused MSBs 0
m_err_frame  out  1  a stop bit sampled 0
m_err_parity  out  1  parity mismatch
m_break  out  1  break condition; m_data = 0
m_valid  out  1  output word valid
m_ready  in  1  consumer accepts when m_valid & m_ready
err_overrun  out  1  one-cycle pulse: completed frame dropped because the holding register was full

Behaviour:
Reset and synchroniser
- On reset: sync flops = 1, state IDLE, all outputs 0.
- Reset mid-frame aborts the frame; no m_valid is produced.
- rx passes through SYNC_STAGES flops to give rx_s. All FSM logic uses rx_s.

Timing base
- Let H = OVERSAMPLE/2.
- The FSM and tick counter cnt (0..OVERSAMPLE-1) advance only on cycles with baud_tick = 1.
- In each bit, votes are taken at cnt = H-1, H and H+1. The bit value is the majority, decided at cnt = H+1.
- The bit boundary is where cnt wraps from OVERSAMPLE-1 to 0.

State machine
- IDLE: on a tick with rx_s = 0, go to START with cnt = 1, and latch cfg_bits, cfg_parity and cfg_stop2. Configuration changes mid-frame have no effect.
- START: at the decision point, vote = 1 is a glitch; return to IDLE with no output. Otherwise, at the wrap go to DATA with bit index 0.
- DATA: at the decision, write the vote to data[idx]. At the wrap, idx++. After cfg_bits bits, go to PARITY if parity is enabled, else STOP.
- PARITY: the expected parity bit is ^data for even, ~^data for odd; a mismatch sets perr. At the wrap, go to STOP.
- STOP: at the decision of each stop bit, vote = 0 sets ferr.
  - If cfg_stop2 = 1: at the first stop bit's wrap, take a second stop bit.
  - At the decision of the last stop bit, complete the frame and go to IDLE immediately. This gives a half-bit resync margin.

Break
- Break = all data bits 0, the parity bit 0 (if enabled) and the first stop bit 0.
- On break: deliver m_break = 1, m_err_frame = 1, m_err_parity = 0, m_data = 0, then go to BREAK_WAIT.
- BREAK_WAIT: wait for a tick with rx_s = 1, then go to IDLE.

Output register
- On completion with m_valid = 0, or with m_valid & m_ready in the same cycle: load m_data and status, and set m_valid = 1.
- On completion with m_valid = 1 & m_ready = 0: drop the new frame, keep the held word, and pulse err_overrun for 1 cycle.
- m_valid & m_ready with no completion clears m_valid.
- Outputs remain stable while m_valid & !m_ready.
- Latency: m_valid rises 1 clk after the baud_tick carrying the last stop-bit decision.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK_WAIT);
  - the parity mode constants PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2.
- Sub-module uart_rx_sampler contains the SYNC_STAGES synchroniser, the tick counter and the 3-sample majority vote. It outputs rx_s, a vote-valid strobe at cnt = H+1, a wrap strobe and the vote value.

Test Plan:
1. 8N1, OVERSAMPLE 16, send 0xA5, m_ready = 1 -> m_data = 0x0A5, m_valid one cycle, no error flags.
2. cfg 7E2, send 0x41 with a wrong parity bit -> m_data = 0x41, m_err_parity = 1, m_err_frame = 0. Repeat with the second stop bit = 0 -> m_err_frame = 1.
3. Majority and glitch: rx low for 4 ticks only -> no m_valid, FSM back in IDLE. Single-tick inversion at cnt = H inside a data bit of 0x3C -> still 0x3C.
4. Overrun: m_ready = 0, send 0x11 then 0x22 -> err_overrun pulses once, m_data stays 0x11. Raise m_ready -> one transfer of 0x11.
5. Break: rx low for 2 frame times, then high -> one word with m_break = 1, m_err_frame = 1, m_data = 0. Next frame 0x55 is received correctly.
6. Reset asserted during DATA bit 3 -> no m_valid, all outputs 0. Frame 0x9C sent afterwards is received correctly. A cfg_bits change mid-frame does not affect the current frame.
